// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants and helpers
package vga_timing_pkg;

    localparam int H_VIS_DEF   = 640;
    localparam int H_FP_DEF    = 16;
    localparam int H_SW_DEF    = 96;
    localparam int H_BP_DEF    = 48;
    localparam int V_VIS_DEF   = 480;
    localparam int V_FP_DEF    = 10;
    localparam int V_SW_DEF    = 2;
    localparam int V_BP_DEF    = 33;
    localparam int CLK_DIV_DEF = 2;

    localparam int H_TOT = H_VIS_DEF + H_FP_DEF + H_SW_DEF + H_BP_DEF;
    localparam int V_TOT = V_VIS_DEF + V_FP_DEF + V_SW_DEF + V_BP_DEF;

    localparam int CNT_W = 10;
    localparam int DIV_W = 4;

    function automatic int axis_total(input int vis, input int fp, input int sw, input int bp);
        return vis + fp + sw + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: count, wrap, registered sync, next-state visibility
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VIS = H_VIS_DEF,
    parameter int FP  = H_FP_DEF,
    parameter int SW  = H_SW_DEF,
    parameter int BP  = H_BP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o,
    output logic             sync_o,
    output logic             vis_nxt_o
);

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(axis_total(VIS, FP, SW, BP) - 1);
    localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(VIS + FP);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(VIS + FP + SW);
    localparam logic [CNT_W-1:0] VIS_END  = CNT_W'(VIS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync_q, sync_d;

    // Sync and visibility are derived from the next count so they land on the same edge as it.
    always_comb begin
        wrap_o = step_i && (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (step_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
        sync_d    = !((cnt_d >= SYNC_BEG) && (cnt_d < SYNC_END));
        vis_nxt_o = (cnt_d < VIS_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sync_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= sync_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign sync_o = sync_q;

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA sync generator: pixel divider plus horizontal and vertical axes
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VIS   = H_VIS_DEF,
    parameter int H_FP    = H_FP_DEF,
    parameter int H_SW    = H_SW_DEF,
    parameter int H_BP    = H_BP_DEF,
    parameter int V_VIS   = V_VIS_DEF,
    parameter int V_FP    = V_FP_DEF,
    parameter int V_SW    = V_SW_DEF,
    parameter int V_BP    = V_BP_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             hsync,
    output logic             vsync,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             vidon,
    output logic             pix_tick,
    output logic             frame_start
);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic             run_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             vidon_q, frame_start_q;
    logic             h_wrap, v_wrap, h_vis_nxt, v_vis_nxt;

    // The divider holds at zero for the first edge after reset so the first tick lands CLK_DIV edges later.
    assign pix_tick = run_q && (div_q == DIV_MAX);

    always_comb begin
        div_d = '0;
        if (run_q && (div_q != DIV_MAX)) begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            div_q         <= '0;
            vidon_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            run_q         <= 1'b1;
            div_q         <= div_d;
            vidon_q       <= h_vis_nxt && v_vis_nxt;
            frame_start_q <= h_wrap && v_wrap;
        end
    end

    vga_axis_counter #(
        .VIS(H_VIS), .FP(H_FP), .SW(H_SW), .BP(H_BP)
    ) u_h (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_i    (pix_tick),
        .cnt_o     (hc),
        .wrap_o    (h_wrap),
        .sync_o    (hsync),
        .vis_nxt_o (h_vis_nxt)
    );

    vga_axis_counter #(
        .VIS(V_VIS), .FP(V_FP), .SW(V_SW), .BP(V_BP)
    ) u_v (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_i    (h_wrap),
        .cnt_o     (vc),
        .wrap_o    (v_wrap),
        .sync_o    (vsync),
        .vis_nxt_o (v_vis_nxt)
    );

    assign vidon       = vidon_q;
    assign frame_start = frame_start_q;

endmodule
